// File: rtl/dmem_pkg.sv
// Shared types and helpers for the word-organised data memory.
// Holds the access-size and FSM encodings plus lane-mask and store-lane helpers.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  // Byte-lane enables for an access of the given size at byte offset off.
  function automatic logic [3:0] be_mask(size_e size, logic [1:0] off);
    logic [3:0] base;
    case (size)
      SZ_B:    base = 4'b0001;
      SZ_H:    base = 4'b0011;
      SZ_W:    base = 4'b1111;
      default: base = 4'b0000;
    endcase
    return base << off;
  endfunction

  // Replicates right-aligned store data across all lanes so any enabled lane sees it.
  function automatic logic [31:0] store_lanes(size_e size, logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      SZ_B:    lanes = {4{data[7:0]}};
      SZ_H:    lanes = {2{data[15:0]}};
      default: lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path alignment: picks the addressed lanes out of a storage word and
// sign- or zero-extends them to 32 bits according to the access size.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    shifted = word >> {off, 3'b000};
    sign_b  = ~uns & shifted[7];
    sign_h  = ~uns & shifted[15];
    result  = shifted;
    case (size)
      SZ_B:    result = {{24{sign_b}}, shifted[7:0]};
      SZ_H:    result = {{16{sign_h}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word access, an in-block clear
// sequencer, fault detection and registered load response.
module data_mem
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              clr_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(DEPTH_BYTES);

  state_e            state;
  logic [IDX_W-1:0]  clr_idx;
  logic              rvalid_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic [31:0]       mem [WORDS];

  size_e             size;
  logic [1:0]        off;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              store_en;
  logic [3:0]        be;
  logic [31:0]       lanes;
  logic [31:0]       load_data;

  assign size  = size_e'(size_i);
  assign off   = addr_i[1:0];
  assign idx   = addr_i[IDX_W+1:2];
  assign be    = be_mask(size, off);
  assign lanes = store_lanes(size, wdata_i);

  // clr_i wins over a simultaneous request, so it gates acceptance.
  assign accept = req_i && (state == IDLE) && !clr_i;

  always_comb begin
    misaligned   = 1'b0;
    out_of_range = (addr_i >> OFF_W) != '0;
    case (size)
      SZ_H:    misaligned = off[0];
      SZ_W:    misaligned = off != 2'b00;
      SZ_X:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
    fault = misaligned || out_of_range;
  end

  assign store_en = accept && we_i && !fault;

  dmem_load_align u_align (
    .word   (mem[idx]),
    .off    (off),
    .size   (size),
    .uns    (unsigned_i),
    .result (load_data)
  );

  // NOTE: the storage array has no reset; the CLEAR sequence zeroes it word by word instead.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= lanes[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == IDX_W'(WORDS - 1)) state <= IDLE;
        end
        IDLE: begin
          if (clr_i) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end else if (accept) begin
            err_q <= fault;
            if (!we_i) begin
              rvalid_q <= 1'b1;
              rdata_q  <= fault ? '0 : load_data;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign ready_o  = (state == IDLE);
  assign busy_o   = (state == CLEAR);
  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: byte-array reference model compared every
// cycle, directed literal checks, and randomized load/store/clear traffic.
module tb_data_mem;

  localparam int DEPTH = 64;
  localparam int WORDS = DEPTH / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        clr = 1'b0;
  logic        ready;
  logic        busy;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  int checks = 0;
  int errors = 0;

  data_mem #(.DEPTH_BYTES(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .size_i     (size),
    .unsigned_i (uns),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .clr_i      (clr),
    .ready_o    (ready),
    .busy_o     (busy),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a flat byte array, clear as a countdown.
  logic [7:0]  mm [DEPTH];
  int          busy_left;
  logic        exp_rvalid;
  logic        exp_err;
  logic [31:0] exp_rdata;

  function automatic bit is_fault(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a >= DEPTH);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n = 1 << sz;
    int base = int'(a[5:0]);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[base + i]) << (8 * i));
    if (sz < 2'd2 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_left  = WORDS;
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      exp_rdata  = '0;
      for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
    end else begin
      exp_rvalid = 1'b0;
      exp_err    = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
      end else if (clr) begin
        busy_left = WORDS;
        for (int i = 0; i < DEPTH; i++) mm[i] = 8'h00;
      end else if (req) begin
        if (is_fault(size, addr)) begin
          exp_err = 1'b1;
          if (!we) begin
            exp_rvalid = 1'b1;
            exp_rdata  = '0;
          end
        end else if (we) begin
          for (int i = 0; i < (1 << size); i++) mm[int'(addr[5:0]) + i] = 8'(wdata >> (8 * i));
        end else begin
          exp_rvalid = 1'b1;
          exp_rdata  = model_read(addr, size, uns);
        end
      end
    end
  end

  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      check("ready", 32'(ready), 32'(busy_left == 0));
      check("busy", 32'(busy), 32'(busy_left != 0));
      check("rvalid", 32'(rvalid), 32'(exp_rvalid));
      check("err", 32'(err), 32'(exp_err));
      check("rdata", rdata, exp_rdata);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d, input logic c);
    @(posedge clk);
    #1;
    req = r; we = w; size = s; uns = u; addr = a; wdata = d; clr = c;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic load_check(input string name, input logic [31:0] a, input logic [1:0] s,
                            input logic u, input logic [31:0] exp);
    drive(1'b1, 1'b0, s, u, a, 32'h0, 1'b0);
    idle();
    @(negedge clk);
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check(name, rdata, exp);
  endtask

  task automatic fault_check(input string name, input logic w, input logic [1:0] s, input logic [31:0] a);
    drive(1'b1, w, s, 1'b0, a, 32'hFFFF_FFFF, 1'b0);
    idle();
    @(negedge clk);
    check({name, "_err"}, 32'(err), 32'd1);
    check({name, "_rvalid"}, 32'(rvalid), 32'(!w));
    if (!w) check({name, "_rdata"}, rdata, 32'h0);
  endtask

  // Counts busy cycles (bounded) and any response pulses seen while busy.
  task automatic wait_ready(output int n, output int pulses);
    n = 0;
    pulses = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      if (rvalid || err) pulses++;
      @(negedge clk);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    logic        r, w, u, c;
    logic [1:0]  s;
    logic [31:0] a;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0;
    wait_ready(n, pulses);
    check("reset_clear_cycles", n, WORDS);
    check("clear_silent", pulses, 0);
    idle();

    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0);
    load_check("lb_s_13", 32'h13, 2'd0, 1'b0, 32'hFFFF_FFDE);
    load_check("lh_u_12", 32'h12, 2'd1, 1'b1, 32'h0000_DEAD);
    load_check("lw_10", 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);
    load_check("lh_s_10", 32'h10, 2'd1, 1'b0, 32'hFFFF_BEEF);

    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0);
    drive(1'b1, 1'b1, 2'd0, 1'b0, 32'h21, 32'hABCD_EF7F, 1'b0);
    load_check("byte_merge", 32'h20, 2'd2, 1'b0, 32'h1122_7F44);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h24, 32'hCAFE_F00D, 1'b0);
    load_check("st_ld_b2b", 32'h24, 2'd2, 1'b0, 32'hCAFE_F00D);

    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h04, 32'h0102_0304, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h00, 32'h0506_0708, 1'b0);
    fault_check("f_lw_06", 1'b0, 2'd2, 32'h06);
    fault_check("f_sh_03", 1'b1, 2'd1, 32'h03);
    fault_check("f_ld_sz3", 1'b0, 2'd3, 32'h10);
    fault_check("f_st_sz3", 1'b1, 2'd3, 32'h10);
    fault_check("f_ld_range", 1'b0, 2'd2, 32'(DEPTH));
    fault_check("f_st_range", 1'b1, 2'd2, 32'(DEPTH));
    fault_check("f_st_high", 1'b1, 2'd2, 32'h8000_0010);
    load_check("keep_00", 32'h00, 2'd2, 1'b0, 32'h0506_0708);
    load_check("keep_04", 32'h04, 2'd2, 1'b0, 32'h0102_0304);
    load_check("keep_10", 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF);

    drive(1'b1, 1'b1, 2'd1, 1'b0, 32'h08, 32'h0000_A5A5, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h34, 32'h1234_5678, 1'b1);
    @(negedge clk);
    check("pre_clr_rvalid", 32'(rvalid), 32'd1);
    check("pre_clr_rdata", rdata, 32'h0000_A5A5);
    idle();
    wait_ready(n, pulses);
    check("clr_cycles", n, WORDS);
    check("clr_silent", pulses, 0);
    load_check("clr_34", 32'h34, 2'd2, 1'b0, 32'h0);
    load_check("clr_10", 32'h10, 2'd2, 1'b0, 32'h0);

    drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
    idle();
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_clr_busy", 32'(busy), 32'd1);
    check("rst_mid_clr_ready", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(n, pulses);
    check("rst_mid_clr_cycles", n, WORDS);

    drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h18, 32'h7777_8888, 1'b0);
    drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h18, 32'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    req = 1'b0;
    #1;
    check("rst_inflight_rvalid", 32'(rvalid), 32'd0);
    check("rst_inflight_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready(n, pulses);
    check("rst_inflight_cycles", n, WORDS);
    load_check("rst_zeroed_18", 32'h18, 2'd2, 1'b0, 32'h0);

    for (int k = 0; k < 800; k++) begin
      r = ($urandom % 10) < 7;
      w = $urandom % 2;
      s = ($urandom % 16 == 0) ? 2'd3 : 2'($urandom % 3);
      u = $urandom % 2;
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom % 4 != 0 && s != 2'd3) a = a & ~(32'((1 << s) - 1));
      if ($urandom % 32 == 0) a = $urandom;
      c = ($urandom % 100) == 0;
      drive(r, w, s, u, a, $urandom, c);
    end
    idle();
    repeat (WORDS + 4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Parametrised successor to the 32-entry byte RAM: a word-organised data memory with byte, half and word access, byte-lane write enables and sign/zero-extended reads.
- Contains an in-block clear sequencer that zeroes storage after reset or on request.
- Sits on the core's load/store path behind a req/ready handshake, with registered read data and an error flag.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least 8.
- ADDR_W, 32, width of the incoming byte address.
- WORDS, DEPTH_BYTES/4, derived local parameter: number of 32-bit storage words.
- IDX_W, $clog2(WORDS), derived local parameter: word index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  1  access request
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsigned_i  in  1  load zero-extend (1) or sign-extend (0)
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- clr_i  in  1  request a full memory clear
- ready_o  out  1  block accepts a request this cycle
- busy_o  out  1  clear sequence in progress
- rvalid_o  out  1  load data valid (one-cycle pulse)
- rdata_o  out  32  aligned, extended load data
- err_o  out  1  access fault (one-cycle pulse)

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low.
- Reset values: ready_o=0, busy_o=1, rvalid_o=0, rdata_o=0, err_o=0. The FSM resets to CLEAR with clear index 0.
- Storage array is not reset; the FSM zeroes it instead.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Writes 0 to word[idx] each cycle, idx = 0..WORDS-1.
  - After writing WORDS-1, goes to IDLE. Duration is exactly WORDS cycles after reset deassertion.
  - ready_o=0 and busy_o=1 throughout. req_i is ignored, with no response.
- IDLE:
  - ready_o=1, busy_o=0.
  - clr_i=1 → CLEAR with idx=0, taking effect next cycle. If req_i is also high that cycle, clr_i has priority and the request is not accepted (ready_o is still 1 that cycle, but the FSM drops the request; clr_i gates acceptance).
- Accept condition: req_i && ready_o && !clr_i.
- Fault, checked on accept:
  - size_i==11.
  - Half with addr[0]=1.
  - Word with addr[1:0]!=0.
  - addr_i >= DEPTH_BYTES.
  - On a fault: no write occurs; err_o=1 next cycle. For a faulting load, rvalid_o=1 and rdata_o=0 next cycle.
- Store (no fault):
  - Byte-enable mask is 0001/0011/1111 shifted left by addr[1:0].
  - Data is replicated to the addressed lanes.
  - Written at the clock edge of acceptance; no response pulse.
- Load (no fault):
  - Latency 1: rvalid_o=1 in the cycle after acceptance.
  - Lanes selected by addr[1:0], then extended per size_i and unsigned_i.
  - A word load ignores unsigned_i.
- Outputs:
  - rdata_o holds its value until the next load response.
  - rvalid_o and err_o are single-cycle pulses.
- Back-to-back accesses are accepted every cycle in IDLE.
- A load following a store to the same word on the next cycle returns the new data.
- A load accepted in the cycle before entering CLEAR still delivers its response.
- Address bits above log2(DEPTH_BYTES) must be zero, otherwise the access faults (covered by the range check).
- Reset asserted mid-clear or mid-access: all outputs return to reset values immediately, and the clear restarts from idx 0 after release.

Decomposition:
- dmem_pkg:
  - size_e enum (SZ_B, SZ_H, SZ_W, SZ_X).
  - state_e (CLEAR, IDLE).
  - Function be_mask(size, off) returning a 4-bit mask.
- Sub-module dmem_load_align: combinational lane select plus sign/zero extend. Inputs: 32-bit word, offset, size, unsigned. Output: 32-bit result.
- Top level holds the FSM, clear counter, fault check, byte-enable write and response registers.

Test Plan:
- Reset release with DEPTH_BYTES=64 → ready_o=0 and busy_o=1 for exactly 16 cycles, then ready_o=1. A req_i during those cycles produces no rvalid_o or err_o.
- Store word 0xDEADBEEF @0x10, then load signed byte @0x13 → rdata_o=0xFFFFFFDE. Load unsigned half @0x12 → 0x0000DEAD. Load word @0x10 → 0xDEADBEEF, each 1 cycle after acceptance.
- Store byte 0x7F @0x21 over a word previously holding 0x11223344 → load word @0x20 returns 0x11227F44.
- Faults: word load @0x06, half store @0x03, size 11, and addr=DEPTH_BYTES → each gives err_o pulse; loads give rvalid_o with rdata_o=0. Memory is unchanged, checked by read-back.
- Store nonzero data, then pulse clr_i together with req_i → request dropped, busy_o=1 for WORDS cycles, and subsequent loads return 0.
- Assert rst_n=0 midway through a clear, and again with a load in flight → rvalid_o=0 immediately; after release, the full WORDS-cycle clear repeats.
